s3_power_controller: RTL
========================

// Module: s3_power_controller
// PURPOSE
//  Sequences ALU entry into and exit from S3 (suspend-to-RAM). Watches ALU idle/interrupt,
//  drives s3_state so the ALU captures its operands, writes that context to RAM, and requests clock gating.
//  On wake it reads the context back and presents it for replay before releasing s3_state.
//  Sits between the ALU, the context RAM and the top-level clock-gate cell.
// PARAMETERS
//  IDLE_THRESH  10  consecutive alu_idle cycles that trigger S3 entry (1..1023)
//  ADDR_W       4   RAM address width
//  CTX_ADDR     0   RAM word address used for the ALU context
// PORTS
//  clk             in   1       system clock
//  reset           in   1       asynchronous, active-high reset
//  alu_idle        in   1       ALU idle flag
//  alu_interrupt   in   1       ALU idle-timeout interrupt
//  wake_req        in   1       wake request (level, sampled every cycle)
//  saved_a/saved_b in   4 each  ALU saved operands
//  saved_opcode    in   2       ALU saved opcode
//  ram_ready       in   1       RAM completes the current request this cycle
//  ram_rdata       in   10      RAM read data {opcode,a,b}
//  s3_state        out  1       to ALU: capture context / hold
//  ram_we, ram_re  out  1 each  RAM write/read request (held until ram_ready)
//  ram_addr        out  ADDR_W  always CTX_ADDR while a request is active, else 0
//  ram_wdata       out  10      {saved_opcode,saved_a,saved_b}
//  clk_gate_en     out  1       1 = ALU clock running; 0 = gate request
//  restore_valid   out  1       one-cycle pulse: restore_* valid
//  restore_a/b     out  4 each  restored operands
//  restore_opcode  out  2       restored opcode
//  pstate          out  3       current FSM state encoding (debug)
// BEHAVIOUR
//  Reset: state ACTIVE; s3_state=0, ram_we=ram_re=0, ram_addr=0, ram_wdata=0, clk_gate_en=1,
//   restore_*=0, restore_valid=0, idle_cnt=0, wake_pend=0. Reset mid-sequence aborts immediately.
//  ACTIVE: idle_cnt++ (saturating) while alu_idle, cleared otherwise. alu_interrupt=1 or
//   idle_cnt==IDLE_THRESH-1 with alu_idle=1 -> CAPTURE next edge.
//  CAPTURE (1 cycle): s3_state=1; ALU latches saved_* at this edge -> SAVE.
//  SAVE: s3_state=1, ram_we=1, ram_wdata registered from saved_* on entry; held stable until
//   ram_ready=1 -> SLEEP. No timeout.
//  SLEEP: s3_state=1, clk_gate_en=0. wake_req=1 -> RESTORE.
//  RESTORE: clk_gate_en=1, ram_re=1 until ram_ready; ram_rdata captured into restore_* that cycle -> RESUME.
//  RESUME (1 cycle): restore_valid=1, s3_state=0 -> ACTIVE, idle_cnt=0.
//  wake_req during CAPTURE/SAVE: latched in wake_pend; the save always completes; SLEEP is then
//   skipped (SAVE -> RESTORE directly), clk_gate_en never drops. wake_pend clears on RESTORE entry.
//  wake_req in ACTIVE/RESUME: ignored. alu_interrupt and idle threshold reached in the same cycle: single entry.
//  ram_we and ram_re are never high together. Latency: idle trigger -> SLEEP = 2 + RAM write cycles.
// CONFIGURATION
//  S3_WAKE_DEBOUNCE_EN defined: wake_req must be high for 3 consecutive sampled cycles
//   (2-flop sync + 3-bit shift register) before leaving SLEEP; wake_pend uses the same filtered signal.
//  Undefined: wake_req acts on first high sample; no synchroniser.
// STRUCTURE
//  Shared package s3_pkg: state enum (ACTIVE, CAPTURE, SAVE, SLEEP, RESTORE, RESUME, 3-bit),
//   CTX_W=10 constant, context field offsets. FSM, idle counter and RAM handshake in this module.
//  Optional sub-module s3_wake_filter (sync + debounce), instantiated only under S3_WAKE_DEBOUNCE_EN.
// TESTING
//  1 alu_idle=1 held, IDLE_THRESH=10 -> CAPTURE after 10th idle cycle, s3_state=1, then ram_we=1.
//  2 saved a=5,b=3,op=01, ram_ready after 2 cycles -> ram_wdata=0x153 held, SLEEP, clk_gate_en=0.
//  3 SLEEP, wake_req pulse, ram_rdata=0x153 -> restore_a=5,b=3,op=01, restore_valid one cycle, s3_state=0.
//  4 wake_req during SAVE -> write completes, RESTORE without clk_gate_en ever going low.
//  5 reset asserted in SAVE -> all outputs reset values the same cycle, ACTIVE afterwards.
//  6 DEBOUNCE_EN: 2-cycle wake glitch -> stays SLEEP; 3-cycle wake -> RESTORE.

Source files
------------

// File: rtl/s3_pkg.sv
// Shared types for the S3 suspend/resume controller: FSM state encoding and
// the {opcode, a, b} context word layout written to and read from RAM.
package s3_pkg;

  localparam int CTX_W      = 10;
  localparam int CTX_B_LSB  = 0;
  localparam int CTX_A_LSB  = 4;
  localparam int CTX_OP_LSB = 8;

  typedef enum logic [2:0] {
    ST_ACTIVE  = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SAVE    = 3'd2,
    ST_SLEEP   = 3'd3,
    ST_RESTORE = 3'd4,
    ST_RESUME  = 3'd5
  } state_e;

  function automatic logic [CTX_W-1:0] pack_ctx(input logic [1:0] op,
                                                 input logic [3:0] a,
                                                 input logic [3:0] b);
    return {op, a, b};
  endfunction

endpackage

// File: rtl/s3_wake_filter.sv
// Wake request conditioner: two-flop synchroniser followed by a 3-sample
// debounce; the output is high only after three consecutive high samples.
module s3_wake_filter (
  input  logic clk,
  input  logic reset,
  input  logic wake_req_i,
  output logic wake_o
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;

  // Synchronise the raw request, then shift it into the debounce history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      hist_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[0], wake_req_i};
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  assign wake_o = &hist_q;

endmodule

// File: rtl/s3_power_controller.sv
// S3 entry/exit sequencer: saves ALU context to RAM, gates the ALU clock while
// asleep and replays the restored context on wake. Optional S3_WAKE_DEBOUNCE_EN.
module s3_power_controller
  import s3_pkg::*;
#(
  parameter int IDLE_THRESH = 10,
  parameter int ADDR_W      = 4,
  parameter int CTX_ADDR    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_idle,
  input  logic              alu_interrupt,
  input  logic              wake_req,
  input  logic [3:0]        saved_a,
  input  logic [3:0]        saved_b,
  input  logic [1:0]        saved_opcode,
  input  logic              ram_ready,
  input  logic [9:0]        ram_rdata,
  output logic              s3_state,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [9:0]        ram_wdata,
  output logic              clk_gate_en,
  output logic              restore_valid,
  output logic [3:0]        restore_a,
  output logic [3:0]        restore_b,
  output logic [1:0]        restore_opcode,
  output logic [2:0]        pstate
);

  localparam logic [9:0] IDLE_MAX  = 10'd1023;
  localparam logic [9:0] THRESH_M1 = 10'(IDLE_THRESH - 1);

  state_e           state_q, state_d;
  logic [9:0]       idle_cnt_q, idle_cnt_d;
  logic             wake_pend_q, wake_pend_d;
  logic [CTX_W-1:0] wdata_q, restore_q;
  logic             wake_s;
  logic             enter_s;

`ifdef S3_WAKE_DEBOUNCE_EN
  s3_wake_filter u_wake_filter (
    .clk        (clk),
    .reset      (reset),
    .wake_req_i (wake_req),
    .wake_o     (wake_s)
  );
`else
  assign wake_s = wake_req;
`endif

  // Interrupt and threshold in the same cycle collapse into one entry
  assign enter_s = alu_interrupt | (alu_idle & (idle_cnt_q == THRESH_M1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACTIVE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE:  if (enter_s) state_d = ST_CAPTURE; else state_d = ST_ACTIVE;
      ST_CAPTURE: state_d = ST_SAVE;
      ST_SAVE: begin
        if (ram_ready) begin
          if (wake_pend_q | wake_s) state_d = ST_RESTORE;
          else                      state_d = ST_SLEEP;
        end else begin
          state_d = ST_SAVE;
        end
      end
      ST_SLEEP:   if (wake_s) state_d = ST_RESTORE; else state_d = ST_SLEEP;
      ST_RESTORE: if (ram_ready) state_d = ST_RESUME; else state_d = ST_RESTORE;
      ST_RESUME:  state_d = ST_ACTIVE;
      default:    state_d = ST_ACTIVE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    s3_state      = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    clk_gate_en   = 1'b1;
    restore_valid = 1'b0;
    case (state_q)
      ST_ACTIVE:  s3_state = 1'b0;
      ST_CAPTURE: s3_state = 1'b1;
      ST_SAVE: begin
        s3_state = 1'b1;
        ram_we   = 1'b1;
      end
      ST_SLEEP: begin
        s3_state    = 1'b1;
        clk_gate_en = 1'b0;
      end
      ST_RESTORE: begin
        s3_state = 1'b1;
        ram_re   = 1'b1;
      end
      ST_RESUME:  restore_valid = 1'b1;
      default:    s3_state = 1'b0;
    endcase
  end

  // Idle counter and wake latch next-state
  always_comb begin
    idle_cnt_d  = 10'd0;
    wake_pend_d = wake_pend_q;
    if (state_q == ST_ACTIVE && alu_idle) begin
      idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? IDLE_MAX : idle_cnt_q + 10'd1;
    end else begin
      idle_cnt_d = 10'd0;
    end
    if (state_d == ST_RESTORE && state_q != ST_RESTORE) begin
      wake_pend_d = 1'b0;
    end else if ((state_q == ST_CAPTURE || state_q == ST_SAVE) && wake_s) begin
      wake_pend_d = 1'b1;
    end else begin
      wake_pend_d = wake_pend_q;
    end
  end

  // Idle counter and pending-wake registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q  <= 10'd0;
      wake_pend_q <= 1'b0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      wake_pend_q <= wake_pend_d;
    end
  end

  // Context capture on SAVE entry and on the RAM read completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdata_q   <= '0;
      restore_q <= '0;
    end else begin
      if (state_q == ST_CAPTURE) begin
        wdata_q <= pack_ctx(saved_opcode, saved_a, saved_b);
      end
      if (state_q == ST_RESTORE && ram_ready) begin
        restore_q <= ram_rdata;
      end
    end
  end

  assign ram_wdata      = wdata_q;
  assign ram_addr       = (ram_we | ram_re) ? ADDR_W'(CTX_ADDR) : {ADDR_W{1'b0}};
  assign restore_opcode = restore_q[CTX_OP_LSB +: 2];
  assign restore_a      = restore_q[CTX_A_LSB +: 4];
  assign restore_b      = restore_q[CTX_B_LSB +: 4];
  assign pstate         = state_q;

endmodule
